// File: rtl/mem_port.sv
// mem_port: memory-side initiator between the CPU datapath and the unclocked RAM.
// It accepts one load or store at a time and keeps address and data stable
// around each RAM strobe. Load data is captured into a response register.
// Optional feature macro: MEM_PORT_BOUNDS_CHECK_EN. When it is defined,
// addresses at or above DEPTH are rejected with rsp_err. When it is not
// defined, addresses wrap modulo DEPTH.
module mem_port #(
    parameter int DEPTH     = 512,
    parameter int READ_WAIT = 1,
    parameter int WR_PULSE  = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_WAIT,
        WR_STROBE,
        WR_HOLD,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        capture;
    logic        accept;
    logic        addr_bad;
    logic        op_w;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    assign accept = (state == IDLE) && req_valid;

`ifdef MEM_PORT_BOUNDS_CHECK_EN
    logic err_q;

    assign addr_bad    = (req_addr >= 32'(DEPTH));
    assign mem_address = addr_q;
    assign rsp_err     = (state == RESP) && err_q;

    // Remember whether the accepted request was rejected, for the response
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_bad;
        end
    end
`else
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Upper address bits are dropped so the RAM sees the address modulo DEPTH
    logic unused_addr_hi;

    assign addr_bad       = 1'b0;
    assign mem_address    = {{(32 - AW){1'b0}}, addr_q[AW-1:0]};
    assign rsp_err        = 1'b0;
    assign unused_addr_hi = ^addr_q[31:AW];
`endif

    // Handshake and strobes decode straight from state, so an async reset drops them at once
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign mem_read    = (state == RD_WAIT);
    assign mem_write   = (state == WR_STROBE);
    assign mem_data_in = wdata_q;
    assign rsp_rdata   = rdata_q;

    // State and wait-counter register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: load the counter in SETUP, then count down through the strobe
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = addr_bad ? RESP : SETUP;
                end
            end
            SETUP: begin
                if (op_w) begin
                    cnt_nxt   = WR_LOAD;
                    state_nxt = WR_STROBE;
                end else begin
                    cnt_nxt   = RD_LOAD;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            WR_STROBE: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request; address and data stay put until the next accept
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_w    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            op_w    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Capture read data after mem_read has been held for READ_WAIT cycles
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rdata_q <= 32'd0;
        end else if (capture) begin
            rdata_q <= mem_data_out;
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// tb_mem_port: directed and random requests against mem_port.
// A 512-word RAM model surrounds the design. A separate reference model
// predicts RAM contents, latency, strobe lengths and response values.
`timescale 1ns/1ps
module tb_mem_port;
    localparam int DEPTH = 512;
    localparam int RW    = 3;
    localparam int WP    = 2;
    localparam int BOUND = 60;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;

    int checks = 0;
    int errors = 0;

    // environment RAM: unwritten words read back a fixed pattern
    logic [31:0] bench_ram [DEPTH];
    bit          written   [DEPTH];
    // reference model
    logic [31:0] ref_ram   [DEPTH];
    logic [31:0] ref_rdata;
    // noise source that changes mid-cycle, used to check read sampling time
    logic        noise_en = 1'b0;
    logic [31:0] noise    = 32'd0;

    mem_port #(.DEPTH(DEPTH), .READ_WAIT(RW), .WR_PULSE(WP)) dut (
        .clk          (clk),
        .clr          (clr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [8:0] a);
        logic [31:0] x;
        x = {23'd0, a};
        if (a == 9'h095) return 32'h0000_000D;
        return (x * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [8:0] a);
        return written[a] ? bench_ram[a] : init_val(a);
    endfunction

    assign mem_data_out = noise_en ? (32'hA000_0000 + noise) : ram_rd(mem_address[8:0]);

    always @(posedge clk) begin
        if (mem_write) begin
            bench_ram[mem_address[8:0]] <= mem_data_in;
            written[mem_address[8:0]]   <= 1'b1;
        end
    end

    always @(negedge clk) noise <= noise + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // one request: keep=1 leaves req_valid high with the next request's fields
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit keep, input logic nw, input logic [31:0] na,
                          input logic [31:0] nd);
        int n, lat, rd_n, wr_n, both_n, rdy_n, abad_n, dbad_n, first_wr, last_wr;
        int exp_lat, exp_rd, exp_wr;
        logic bad;
        logic [31:0] exp_addr;
        logic [31:0] n0;
        logic [8:0] eff;
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        n0 = noise;
        if (keep) begin
            req_write = nw;
            req_addr  = na;
            req_wdata = nd;
        end else begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
`ifdef MEM_PORT_BOUNDS_CHECK_EN
        bad      = (a >= 32'(DEPTH));
        exp_addr = a;
`else
        bad      = 1'b0;
        exp_addr = a % 32'(DEPTH);
`endif
        eff = a[8:0];
        if (bad) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (w) begin
            exp_lat = WP + 3; exp_rd = 0; exp_wr = WP;
            ref_ram[eff] = d;
        end else begin
            exp_lat = RW + 2; exp_rd = RW; exp_wr = 0;
            ref_rdata = noise_en ? (32'hA000_0000 + n0 + 32'(RW) + 32'd1) : ref_ram[eff];
        end
        lat = 0; rd_n = 0; wr_n = 0; both_n = 0; rdy_n = 0;
        abad_n = 0; dbad_n = 0; first_wr = 0; last_wr = 0;
        for (int k = 1; k <= BOUND && lat == 0; k++) begin
            @(negedge clk);
            if (mem_read) rd_n++;
            if (mem_write) begin
                wr_n++;
                if (first_wr == 0) first_wr = k;
                last_wr = k;
            end
            if (mem_read && mem_write) both_n++;
            if (req_ready) rdy_n++;
            if (mem_address !== exp_addr) abad_n++;
            if (mem_data_in !== d) dbad_n++;
            if (rsp_valid) begin
                lat = k;
                chk("rsp_err", 32'(rsp_err), 32'(bad));
                chk("rsp_rdata", rsp_rdata, ref_rdata);
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("read_cycles", 32'(rd_n), 32'(exp_rd));
        chk("write_cycles", 32'(wr_n), 32'(exp_wr));
        chk("strobe_overlap", 32'(both_n), 32'd0);
        chk("ready_while_busy", 32'(rdy_n), 32'd0);
        chk("address_held", 32'(abad_n), 32'd0);
        chk("wdata_held", 32'(dbad_n), 32'd0);
        if (w && !bad) begin
            chk("write_first_cycle", 32'(first_wr), 32'd2);
            chk("write_last_cycle", 32'(last_wr), 32'(WP + 1));
        end
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
        chk("strobes_idle", 32'({mem_read, mem_write}), 32'd0);
        chk("ram_word", ram_rd(eff), ref_ram[eff]);
    endtask

    initial begin
        logic [31:0] a, d;
        int rdy_bad, vld_n;
        for (int i = 0; i < DEPTH; i++) ref_ram[i] = init_val(9'(i));
        ref_rdata = 32'd0;
        clr = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_address", mem_address, 32'd0);
        chk("reset_data_in", mem_data_in, 32'd0);
        clr = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // directed load, store, back-to-back, wrap/bounds, read sampling time
        do_req(1'b0, 32'h95, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b1, 32'h87, 32'h43, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b1, 32'h43, 32'd7, 1'b1, 1'b0, 32'h43, 32'h5555_AAAA);
        do_req(1'b0, 32'h43, 32'h5555_AAAA, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b1, 32'h205, 32'h11, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b0, 32'h005, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        noise_en = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        noise_en = 1'b0;

        // random traffic over a small address window so loads hit earlier stores
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h200 + $urandom_range(0, 32'h3FF);
                1:       a = $urandom;
                default: a = 32'h40 + $urandom_range(0, 15);
            endcase
            d = $urandom;
            do_req(1'($urandom), a, d, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // reset in the middle of a write strobe; data equals the old word
        a = 32'h30;
        d = ref_ram[9'h030];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_before_abort", 32'(mem_write), 32'd1);
        #2;
        clr = 1'b0;
        #1;
        chk("abort_write_drops", 32'(mem_write), 32'd0);
        chk("abort_read_low", 32'(mem_read), 32'd0);
        chk("abort_address", mem_address, 32'd0);
        chk("abort_data_in", mem_data_in, 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        ref_rdata = 32'd0;
        @(negedge clk);
        clr = 1'b1;
        rdy_bad = 0;
        vld_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!req_ready) rdy_bad++;
            if (rsp_valid) vld_n++;
        end
        chk("abort_no_response", 32'(vld_n), 32'd0);
        chk("abort_ready", 32'(rdy_bad), 32'd0);
        do_req(1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(1'b0, 32'h87, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
